// File: rtl/edic_dbg_pkg.sv
// ---------------------------------------------------------------------------
// edic_dbg_pkg : command/state encodings shared by the EDiC debug run control
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package edic_dbg_pkg;

  typedef enum logic [2:0] {
    CMD_NOP        = 3'd0,
    CMD_RUN        = 3'd1,
    CMD_HALT       = 3'd2,
    CMD_STEP_CYCLE = 3'd3,
    CMD_STEP_INSTR = 3'd4,
    CMD_STEP_N     = 3'd5,
    CMD_RSVD6      = 3'd6,
    CMD_RSVD7      = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    ST_HALTED     = 2'd0,
    ST_RUN        = 2'd1,
    ST_STEP_CYC   = 2'd2,
    ST_STEP_INSTR = 2'd3
  } state_e;

  function automatic logic is_reserved(input logic [2:0] cmd);
    return (cmd == CMD_RSVD6) || (cmd == CMD_RSVD7);
  endfunction

endpackage

`default_nettype wire

// File: rtl/run_controller.sv
// ---------------------------------------------------------------------------
// run_controller : debug run/step scheduler driving the registered CPU halt
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module run_controller
  import edic_dbg_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8,
  parameter int CYC_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_cmdValid,
  input  logic [2:0]        i_cmd,
  output logic              o_cmdReady,
  input  logic [CNT_W-1:0]  i_stepCount,
  input  logic              i_bpEnable,
  input  logic [ADDR_W-1:0] i_bpAddr,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_instrFinished,
  output logic              o_halt,
  output logic [1:0]        o_state,
  output logic              o_bpHit,
  output logic              o_cmdErr,
  output logic [CYC_W-1:0]  o_cycleCount
);

  state_e             state_q, state_d;
  logic               halt_q, halt_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               bp_hit_q, bp_hit_d;
  logic               cmd_err_q, cmd_err_d;
  logic [CYC_W-1:0]   cycle_q, cycle_d;

  logic               w_accept;
  cmd_e               w_cmd;
  logic               w_bp_match;
  logic               w_halt_cmd;

  assign o_cmdReady = 1'b1;
  assign w_accept   = i_cmdValid & o_cmdReady;
  assign w_cmd      = cmd_e'(i_cmd);
  assign w_halt_cmd = w_accept && (w_cmd == CMD_HALT);
  assign w_bp_match = i_instrFinished && i_bpEnable && (i_pc == i_bpAddr);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    bp_hit_d    = bp_hit_q;
    cmd_err_d   = w_accept && is_reserved(i_cmd);
    cycle_d     = halt_q ? cycle_q : cycle_q + CYC_W'(1);

    case (state_q)
      ST_HALTED: begin
        if (w_accept) begin
          case (w_cmd)
            CMD_RUN: begin
              state_d  = ST_RUN;
              bp_hit_d = 1'b0;
            end
            CMD_STEP_CYCLE: begin
              state_d  = ST_STEP_CYC;
              bp_hit_d = 1'b0;
            end
            CMD_STEP_INSTR: begin
              state_d     = ST_STEP_INSTR;
              remaining_d = CNT_W'(1);
              bp_hit_d    = 1'b0;
            end
            CMD_STEP_N: begin
              if (i_stepCount == '0) begin
                cmd_err_d = 1'b1;
              end else begin
                state_d     = ST_STEP_INSTR;
                remaining_d = i_stepCount;
                bp_hit_d    = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end

      // The single enabled cycle ends regardless; HALT here changes nothing.
      ST_STEP_CYC: begin
        state_d = ST_HALTED;
        if (w_accept && (w_cmd != CMD_NOP) && (w_cmd != CMD_HALT))
          cmd_err_d = 1'b1;
      end

      default: begin  // ST_RUN, ST_STEP_INSTR
        if (w_accept && (w_cmd != CMD_NOP) && (w_cmd != CMD_HALT))
          cmd_err_d = 1'b1;

        // HALT wins, but a coincident breakpoint still records the hit.
        if (w_halt_cmd) begin
          state_d = ST_HALTED;
          if (w_bp_match)
            bp_hit_d = 1'b1;
        end else if (w_bp_match) begin
          state_d  = ST_HALTED;
          bp_hit_d = 1'b1;
        end else if ((state_q == ST_STEP_INSTR) && i_instrFinished) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1))
            state_d = ST_HALTED;
        end
      end
    endcase

    if (state_d == ST_HALTED)
      remaining_d = '0;
    halt_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q     <= ST_HALTED;
      halt_q      <= 1'b1;
      remaining_q <= '0;
      bp_hit_q    <= 1'b0;
      cmd_err_q   <= 1'b0;
      cycle_q     <= '0;
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_d;
      remaining_q <= remaining_d;
      bp_hit_q    <= bp_hit_d;
      cmd_err_q   <= cmd_err_d;
      cycle_q     <= cycle_d;
    end
  end

  assign o_halt       = halt_q;
  assign o_state      = state_q;
  assign o_bpHit      = bp_hit_q;
  assign o_cmdErr     = cmd_err_q;
  assign o_cycleCount = cycle_q;

endmodule

`default_nettype wire

// File: tb/tb_run_controller.sv
// ---------------------------------------------------------------------------
// tb_run_controller : table-driven and directed checks of run_controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_run_controller;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd = 3'd0;
  logic        cmd_ready;
  logic [7:0]  step_count = 8'd0;
  logic        bp_enable = 1'b0;
  logic [15:0] bp_addr = 16'h0040;
  logic [15:0] pc = 16'h0000;
  logic        fin = 1'b0;
  logic        halt;
  logic [1:0]  state;
  logic        bp_hit;
  logic        cmd_err;
  logic [31:0] cyc;

  int total = 0;
  int bad   = 0;

  run_controller #(.ADDR_W(16), .CNT_W(8), .CYC_W(32)) dut (
    .i_clk           (clk),
    .i_resetn        (resetn),
    .i_cmdValid      (cmd_valid),
    .i_cmd           (cmd),
    .o_cmdReady      (cmd_ready),
    .i_stepCount     (step_count),
    .i_bpEnable      (bp_enable),
    .i_bpAddr        (bp_addr),
    .i_pc            (pc),
    .i_instrFinished (fin),
    .o_halt          (halt),
    .o_state         (state),
    .o_bpHit         (bp_hit),
    .o_cmdErr        (cmd_err),
    .o_cycleCount    (cyc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [2:0]  cmd;
    logic [7:0]  cnt;
    logic        bpen;
    logic [15:0] pc;
    logic        fin;
    logic [1:0]  st;
    logic        halt;
    logic        bp;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [2:0] c, logic [7:0] n, logic be,
                              logic [15:0] p, logic f, logic [1:0] s,
                              logic h, logic b, logic e);
    vec_t r;
    r.v = v; r.cmd = c; r.cnt = n; r.bpen = be; r.pc = p; r.fin = f;
    r.st = s; r.halt = h; r.bp = b; r.err = e;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cmd_valid = 1'b0; cmd = 3'd0; fin = 1'b0; bp_enable = 1'b0; pc = 16'h0;
  endtask

  task automatic send(input logic [2:0] c);
    cmd_valid = 1'b1; cmd = c;
  endtask

  task automatic do_reset();
    idle();
    #2 resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    logic [31:0] exp_cyc;
    logic        prev_halt;

    // Reset values
    idle();
    tick();
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_halt", {31'd0, halt}, 32'd1);
    check("rst_bp", {31'd0, bp_hit}, 32'd0);
    check("rst_err", {31'd0, cmd_err}, 32'd0);
    check("rst_cyc", cyc, 32'd0);
    check("ready", {31'd0, cmd_ready}, 32'd1);
    resetn = 1'b1;
    tick();

    // RUN at t0, HALT at t0+10
    send(3'd1);
    check("A_halt_t0", {31'd0, halt}, 32'd1);
    tick();
    idle();
    check("A_halt_t1", {31'd0, halt}, 32'd0);
    check("A_state_t1", {30'd0, state}, 32'd1);
    for (int i = 0; i < 9; i++) tick();
    send(3'd2);
    tick();
    idle();
    check("A_halt_after", {31'd0, halt}, 32'd1);
    check("A_state_after", {30'd0, state}, 32'd0);
    check("A_cyc", cyc, 32'd10);

    // STEP_N=3 with finish pulses every 4 cycles
    do_reset();
    send(3'd5); step_count = 8'd3;
    tick();
    idle();
    check("B_state_start", {30'd0, state}, 32'd3);
    for (int i = 1; i <= 12; i++) begin
      fin = (i % 4 == 0);
      pc  = 16'h0100;
      tick();
      fin = 1'b0;
      if (i == 8)  check("B_state_p2", {30'd0, state}, 32'd3);
      if (i == 11) check("B_state_11", {30'd0, state}, 32'd3);
      if (i == 12) begin
        check("B_state_end", {30'd0, state}, 32'd0);
        check("B_halt_end", {31'd0, halt}, 32'd1);
        check("B_cyc", cyc, 32'd12);
      end
    end

    // Single-cycle vectors: inputs, then state/halt/bp/err after the edge
    tbl.push_back(mk(1, 3'd0, 0, 0, 16'h0000, 0, 2'd0, 1, 0, 0)); // NOP halted
    tbl.push_back(mk(1, 3'd2, 0, 0, 16'h0000, 0, 2'd0, 1, 0, 0)); // HALT halted
    tbl.push_back(mk(1, 3'd6, 0, 0, 16'h0000, 0, 2'd0, 1, 0, 1)); // reserved 6
    tbl.push_back(mk(1, 3'd7, 0, 0, 16'h0000, 0, 2'd0, 1, 0, 1)); // reserved 7
    tbl.push_back(mk(1, 3'd5, 0, 0, 16'h0000, 0, 2'd0, 1, 0, 1)); // STEP_N 0
    tbl.push_back(mk(1, 3'd3, 0, 0, 16'h0000, 0, 2'd2, 0, 0, 0)); // STEP_CYCLE
    tbl.push_back(mk(0, 3'd0, 0, 0, 16'h0000, 0, 2'd0, 1, 0, 0)); // back halted
    tbl.push_back(mk(1, 3'd1, 0, 0, 16'h0000, 0, 2'd1, 0, 0, 0)); // RUN
    tbl.push_back(mk(1, 3'd4, 0, 0, 16'h0000, 0, 2'd1, 0, 0, 1)); // STEP_INSTR in RUN
    tbl.push_back(mk(0, 3'd0, 0, 1, 16'h0040, 1, 2'd0, 1, 1, 0)); // bp hit
    tbl.push_back(mk(1, 3'd1, 0, 1, 16'h0000, 0, 2'd1, 0, 0, 0)); // RUN clears bp
    tbl.push_back(mk(0, 3'd0, 0, 1, 16'h0041, 1, 2'd1, 0, 0, 0)); // pc miss
    tbl.push_back(mk(1, 3'd2, 0, 1, 16'h0040, 1, 2'd0, 1, 1, 0)); // HALT + bp
    tbl.push_back(mk(1, 3'd4, 0, 0, 16'h0000, 0, 2'd3, 0, 0, 0)); // STEP_INSTR
    tbl.push_back(mk(0, 3'd0, 0, 0, 16'h0010, 1, 2'd0, 1, 0, 0)); // step done
    tbl.push_back(mk(1, 3'd5, 2, 0, 16'h0000, 0, 2'd3, 0, 0, 0)); // STEP_N 2
    tbl.push_back(mk(0, 3'd0, 0, 1, 16'h0040, 1, 2'd0, 1, 1, 0)); // bp in step
    tbl.push_back(mk(1, 3'd3, 0, 1, 16'h0040, 1, 2'd2, 0, 0, 0)); // fin ignored halted
    tbl.push_back(mk(1, 3'd1, 0, 1, 16'h0040, 1, 2'd0, 1, 0, 1)); // RUN in STEP_CYC
    tbl.push_back(mk(1, 3'd1, 0, 0, 16'h0000, 0, 2'd1, 0, 0, 0)); // RUN
    tbl.push_back(mk(1, 3'd7, 0, 0, 16'h0000, 0, 2'd1, 0, 0, 1)); // reserved in RUN
    tbl.push_back(mk(1, 3'd3, 0, 0, 16'h0000, 0, 2'd1, 0, 0, 1)); // STEP_CYCLE in RUN
    tbl.push_back(mk(1, 3'd2, 0, 0, 16'h0000, 0, 2'd0, 1, 0, 0)); // HALT
    tbl.push_back(mk(0, 3'd0, 0, 1, 16'h0040, 1, 2'd0, 1, 0, 0)); // fin in HALTED
    tbl.push_back(mk(1, 3'd5, 1, 0, 16'h0000, 0, 2'd3, 0, 0, 0)); // STEP_N 1
    tbl.push_back(mk(0, 3'd0, 0, 1, 16'h0040, 1, 2'd0, 1, 1, 0)); // expiry + bp
    tbl.push_back(mk(1, 3'd3, 0, 0, 16'h0000, 0, 2'd2, 0, 0, 0)); // STEP_CYCLE
    tbl.push_back(mk(1, 3'd2, 0, 0, 16'h0000, 0, 2'd0, 1, 0, 0)); // HALT in STEP_CYC
    tbl.push_back(mk(1, 3'd5, 2, 0, 16'h0000, 0, 2'd3, 0, 0, 0)); // STEP_N 2
    tbl.push_back(mk(0, 3'd0, 0, 0, 16'h0005, 1, 2'd3, 0, 0, 0)); // 1 left
    tbl.push_back(mk(0, 3'd0, 0, 0, 16'h0005, 0, 2'd3, 0, 0, 0)); // no pulse
    tbl.push_back(mk(0, 3'd0, 0, 0, 16'h0006, 1, 2'd0, 1, 0, 0)); // expiry

    do_reset();
    exp_cyc   = 32'd0;
    prev_halt = 1'b1;
    foreach (tbl[i]) begin
      cmd_valid  = tbl[i].v;
      cmd        = tbl[i].cmd;
      step_count = tbl[i].cnt;
      bp_enable  = tbl[i].bpen;
      pc         = tbl[i].pc;
      fin        = tbl[i].fin;
      if (!prev_halt) exp_cyc = exp_cyc + 32'd1;
      tick();
      check($sformatf("T%0d_state", i), {30'd0, state}, {30'd0, tbl[i].st});
      check($sformatf("T%0d_halt", i), {31'd0, halt}, {31'd0, tbl[i].halt});
      check($sformatf("T%0d_bp", i), {31'd0, bp_hit}, {31'd0, tbl[i].bp});
      check($sformatf("T%0d_err", i), {31'd0, cmd_err}, {31'd0, tbl[i].err});
      check($sformatf("T%0d_cyc", i), cyc, exp_cyc);
      prev_halt = tbl[i].halt;
    end
    idle();

    // Asynchronous reset in the middle of STEP_N with two instructions left
    send(3'd5); step_count = 8'd3;
    tick();
    idle();
    fin = 1'b1; pc = 16'h0200;
    tick();
    fin = 1'b0;
    check("C_state_pre", {30'd0, state}, 32'd3);
    #2 resetn = 1'b0;
    #1;
    check("C_state_rst", {30'd0, state}, 32'd0);
    check("C_halt_rst", {31'd0, halt}, 32'd1);
    check("C_cyc_rst", cyc, 32'd0);
    check("C_bp_rst", {31'd0, bp_hit}, 32'd0);
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fin = 1'b1; bp_enable = 1'b1; pc = 16'h0040;
      tick();
    end
    idle();
    check("C_state_post", {30'd0, state}, 32'd0);
    check("C_halt_post", {31'd0, halt}, 32'd1);
    check("C_bp_post", {31'd0, bp_hit}, 32'd0);
    check("C_cyc_post", cyc, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
